// File: rtl/lcd_frame_sched_pkg.sv
// Shared types and constants for the LCD frame scheduler: FSM states, speed
// codes, tick multipliers and the picture-step helper.
package lcd_frame_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_REQ,
      ST_DRAW
   } state_e;

   typedef enum logic [1:0] {
      SPD_STOP = 2'b00,
      SPD_SLOW = 2'b01,
      SPD_MED  = 2'b10,
      SPD_FAST = 2'b11
   } speed_e;

   localparam logic [2:0] MULT_SLOW = 3'd4;
   localparam logic [2:0] MULT_MED  = 3'd2;
   localparam logic [2:0] MULT_FAST = 3'd1;

   // Base ticks per advance event; zero means no events.
   function automatic logic [2:0] speed_mult(input logic [1:0] spd);
      logic [2:0] m;
      unique case (speed_e'(spd))
         SPD_SLOW: m = MULT_SLOW;
         SPD_MED:  m = MULT_MED;
         SPD_FAST: m = MULT_FAST;
         default:  m = 3'd0;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] next_pic(input logic [3:0] pic, input logic dir,
                                           input logic [3:0] last);
      logic [3:0] n;
      if (!dir) n = (pic == last) ? 4'd0 : pic + 4'd1;
      else      n = (pic == 4'd0) ? last : pic - 4'd1;
      return n;
   endfunction

endpackage

// File: rtl/lcd_frame_sched_tick_gen.sv
// Free-running base tick timer plus speed-dependent period counter; emits a
// one-cycle advance event. Counters restart whenever speed changes.
module lcd_tick_gen
   import lcd_frame_sched_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   output logic       advance
);

   localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    period_q, period_d;
   logic [1:0]    speed_q;
   logic          tick, changed;
   logic [2:0]    mult;

   always_comb begin
      changed  = (speed != speed_q);
      tick     = (timer_q == TW'(TICK_CYCLES - 1));
      mult     = speed_mult(speed_q);
      timer_d  = timer_q + 1'b1;
      period_d = period_q;
      advance  = 1'b0;
      if (changed || tick) timer_d = '0;
      if (changed || mult == 3'd0) begin
         period_d = '0;
      end else if (tick) begin
         if ({1'b0, period_q} == mult - 3'd1) begin
            period_d = '0;
            advance  = 1'b1;
         end else begin
            period_d = period_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q  <= '0;
         period_q <= '0;
         speed_q  <= '0;
      end else begin
         timer_q  <= timer_d;
         period_q <= period_d;
         speed_q  <= speed;
      end
   end

endmodule

// File: rtl/lcd_frame_sched.sv
// Animation frame scheduler: steps through FRAME_NUM pictures at a selectable
// rate and handshakes each picture with the LCD controller.
module lcd_frame_sched
   import lcd_frame_sched_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 50000,
   parameter int unsigned FRAME_NUM   = 8,
   parameter int unsigned TIMEOUT     = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] speed,
   input  logic       dir,
   input  logic       frame_ack,
   input  logic       frame_done,
   output logic       frame_req,
   output logic [3:0] pic_sel,
   output logic       overrun,
   output logic       timeout_err
);

   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [3:0] LAST_PIC = 4'(FRAME_NUM - 1);

   state_e        state_q, state_d;
   logic [3:0]    pic_q, pic_d;
   logic          pending_q, pending_d;
   logic          overrun_q, overrun_d;
   logic          timeout_q, timeout_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          advance, clear_pend;

   lcd_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .speed   (speed),
      .advance (advance)
   );

   always_comb begin
      state_d    = state_q;
      pic_d      = pic_q;
      timeout_d  = timeout_q;
      clear_pend = 1'b0;
      unique case (state_q)
         ST_IDLE: if (en) state_d = ST_REQ;
         ST_WAIT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (pending_q) begin
               pic_d      = next_pic(pic_q, dir, LAST_PIC);
               clear_pend = 1'b1;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: if (frame_ack) state_d = ST_DRAW;
         ST_DRAW: begin
            if (frame_done) begin
               state_d = ST_WAIT;
            end else if (wd_q == WW'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      wd_d = (state_q == ST_DRAW && state_d == ST_DRAW) ? wd_q + 1'b1 : '0;

      // A new event in the clearing cycle keeps pending set without overrun.
      pending_d = pending_q;
      overrun_d = overrun_q;
      if (advance) begin
         pending_d = 1'b1;
         if (pending_q && !clear_pend) overrun_d = 1'b1;
      end else if (clear_pend) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pic_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         pic_q     <= pic_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         wd_q      <= wd_d;
      end
   end

   assign frame_req   = (state_q == ST_REQ);
   assign pic_sel     = pic_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;

endmodule
